// File: rtl/fft_spectrum_buf.sv
// Ping-pong spectrum buffer behind the FFT magnitude stage: stores the first
// STORE_BINS bins of each frame, tracks the non-DC peak and serves the last full frame.
module fft_spectrum_buf #(
  parameter int unsigned N_FFT      = 2048,
  parameter int unsigned STORE_BINS = 1024,
  parameter int unsigned AW         = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  input  logic          in_flush,
  input  logic          rd_hold,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  output logic          frame_done,
  output logic [7:0]    peak_mag,
  output logic [AW-1:0] peak_bin,
  output logic [7:0]    drop_cnt,
  output logic          busy
);

  localparam int unsigned CW    = $clog2(N_FFT);
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 2 * STORE_BINS;

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   bin_cnt;
  logic            wr_bank;
  logic [DW-1:0]   run_peak;
  logic [AW-1:0]   run_bin;
  logic [DW-1:0]   mem [DEPTH];

  logic            beat_c;
  logic            in_store_c;
  logic            store_c;
  logic            peak_upd_c;
  logic            last_beat_c;
  logic [AW:0]     wr_addr_c;
  logic [AW:0]     rd_idx_c;

  // bin_cnt is 0 whenever the FSM is in IDLE, so the first beat lands on bin 0
  assign beat_c      = in_valid && !in_flush && (state != DONE);
  assign in_store_c  = 32'(bin_cnt) < STORE_BINS;
  assign store_c     = beat_c && in_store_c;
  assign peak_upd_c  = beat_c && (state == FILL) && (bin_cnt != '0) && in_store_c &&
                       (in_data > run_peak);
  assign last_beat_c = bin_cnt == CW'(N_FFT - 1);
  assign wr_addr_c   = {wr_bank, bin_cnt[AW-1:0]};
  assign rd_idx_c    = {~wr_bank, rd_addr};

  // Spectrum RAM: write bank and display bank share one array
  always_ff @(posedge clk) begin
    if (store_c) mem[wr_addr_c] <= in_data;
  end

  // Display-bank read port; on the swap cycle it still reads the old bank
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data <= '0;
    else        rd_data <= mem[rd_idx_c];
  end

  // Frame capture FSM with running peak and bank management
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      bin_cnt    <= '0;
      wr_bank    <= 1'b0;
      run_peak   <= '0;
      run_bin    <= '0;
      frame_done <= 1'b0;
      peak_mag   <= '0;
      peak_bin   <= '0;
      drop_cnt   <= '0;
    end else begin
      frame_done <= 1'b0;
      if (in_flush) begin
        state    <= IDLE;
        busy     <= 1'b0;
        bin_cnt  <= '0;
        run_peak <= '0;
        run_bin  <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (in_valid) begin
              state    <= FILL;
              busy     <= 1'b1;
              bin_cnt  <= CW'(1);
              run_peak <= '0;
              run_bin  <= '0;
            end
          end
          FILL: begin
            if (in_valid) begin
              if (peak_upd_c) begin
                run_peak <= in_data;
                run_bin  <= bin_cnt[AW-1:0];
              end
              if (last_beat_c) begin
                state   <= DONE;
                bin_cnt <= '0;
              end else begin
                bin_cnt <= bin_cnt + CW'(1);
              end
            end
          end
          DONE: begin
            state <= IDLE;
            busy  <= 1'b0;
            if (!rd_hold) begin
              wr_bank    <= ~wr_bank;
              peak_mag   <= run_peak;
              peak_bin   <= run_bin;
              frame_done <= 1'b1;
            end else if (drop_cnt != 8'hFF) begin
              drop_cnt <= drop_cnt + 8'd1;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
